// File: rtl/sort_pkg.sv
// Shared helpers for the bitonic sorting pipeline: stage count, legal lane
// counts and lane slicing.
package sort_pkg;

  localparam int unsigned MAX_N = 16;

  // Compare-exchange stages of a bitonic network over n lanes: k(k+1)/2, k = log2(n).
  function automatic int unsigned stage_count(input int unsigned n);
    int unsigned k;
    k = $clog2(n);
    return (k * (k + 1)) / 2;
  endfunction

  // Only power-of-two lane counts from 2 to MAX_N are supported.
  function automatic bit legal_n(input int unsigned n);
    return (n == 2) || (n == 4) || (n == 8) || (n == MAX_N);
  endfunction

  // Bit offset of lane i in a packed vector of w-bit lanes.
  function automatic int unsigned lane_lo(input int unsigned i, input int unsigned w);
    return i * w;
  endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// One compare-exchange cell. Orders (a, b) into (lo, hi): lo is the smaller
// key when desc = 0, the larger key when desc = 1. The key is {value, index};
// equal keys pass through unswapped.
module sort_cmp_swap #(
  parameter int unsigned W  = 8,
  parameter int unsigned IW = 2
) (
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic          desc,
  input  logic [IW-1:0] idx_a,
  input  logic [IW-1:0] idx_b,
  output logic [W-1:0]  lo,
  output logic [W-1:0]  hi,
  output logic [IW-1:0] idx_lo,
  output logic [IW-1:0] idx_hi
);

  logic a_gt;
  logic a_lt;
  logic swap;

  assign a_gt = {a, idx_a} > {b, idx_b};
  assign a_lt = {a, idx_a} < {b, idx_b};
  assign swap = desc ? a_lt : a_gt;

  // Route the pair to its ordered positions.
  always_comb begin
    lo     = a;
    hi     = b;
    idx_lo = idx_a;
    idx_hi = idx_b;
    if (swap) begin
      lo     = b;
      hi     = a;
      idx_lo = idx_b;
      idx_hi = idx_a;
    end
  end

endmodule

// File: rtl/sort_net_pipe.sv
// Pipelined bitonic sorter: N lanes of W bits, one registered compare-exchange
// stage per network step, per-sample ascending/descending order, and a
// valid/ready handshake in which the whole pipe advances or holds together.
// Optional feature: SORT_NET_IDX_EN tags lanes with their input index, breaks
// ties on that index and presents the permutation on y_idx.
module sort_net_pipe
  import sort_pkg::*;
#(
  parameter int unsigned W = 8,
  parameter int unsigned N = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_desc,
  input  logic [N*W-1:0]             x,
  output logic                       out_valid,
  input  logic                       out_ready,
`ifdef SORT_NET_IDX_EN
  output logic [N*$clog2(N)-1:0]     y_idx,
`endif
  output logic [N*W-1:0]             y
);

  localparam int unsigned K  = $clog2(N);
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned S  = stage_count(N);
  localparam int unsigned DW = N * W;
  localparam int unsigned XW = N * IW;

  if (!legal_n(N)) begin : g_bad_n
    $error("sort_net_pipe: N must be 2, 4, 8 or 16");
  end

  logic             adv;
  logic [S-1:0]     st_v;
  logic [S-1:0]     st_desc;
  logic [DW-1:0]    st_d    [S];
  logic [DW-1:0]    sin_d   [S];
  logic [S-1:0]     sin_desc;
  wire  [S*DW-1:0]  nx_d;
  wire              desc_unused;

`ifdef SORT_NET_IDX_EN
  logic [XW-1:0]    st_idx  [S];
  logic [XW-1:0]    sin_idx [S];
  logic [XW-1:0]    lane_tag;
  wire  [S*XW-1:0]  nx_idx;
`else
  wire  [S*XW-1:0]  idx_unused;
`endif

  assign adv         = !out_valid || out_ready;
  assign in_ready    = adv;
  assign out_valid   = st_v[S-1];
  assign y           = st_d[S-1];
  assign desc_unused = st_desc[S-1];
`ifdef SORT_NET_IDX_EN
  assign y_idx       = st_idx[S-1];
`endif

  // Stage inputs: the first stage reads the ports, later ones the previous register.
  always_comb begin
    sin_d[0]    = x;
    sin_desc[0] = in_desc;
    for (int s = 1; s < int'(S); s++) begin
      sin_d[s]    = st_d[s-1];
      sin_desc[s] = st_desc[s-1];
    end
`ifdef SORT_NET_IDX_EN
    for (int i = 0; i < int'(N); i++) begin
      lane_tag[i*IW +: IW] = IW'(i);
    end
    sin_idx[0] = lane_tag;
    for (int s = 1; s < int'(S); s++) begin
      sin_idx[s] = st_idx[s-1];
    end
`endif
  end

  // Bitonic network: merge phase p, step q compares lanes D = 2^(p-q) apart.
  for (genvar p = 0; p < K; p++) begin : g_p
    for (genvar q = 0; q <= p; q++) begin : g_q
      localparam int unsigned SI = (p * (p + 1)) / 2 + q;
      localparam int unsigned D  = 1 << (p - q);
      for (genvar i = 0; i < N; i++) begin : g_l
        if ((i & D) == 0) begin : g_cx
          localparam int unsigned J   = i + D;
          localparam logic        DIR = ((i >> (p + 1)) & 1) != 0;
          sort_cmp_swap #(.W(W), .IW(IW)) u_cx (
            .a      (sin_d[SI][lane_lo(i, W) +: W]),
            .b      (sin_d[SI][lane_lo(J, W) +: W]),
            .desc   (DIR ^ sin_desc[SI]),
`ifdef SORT_NET_IDX_EN
            .idx_a  (sin_idx[SI][lane_lo(i, IW) +: IW]),
            .idx_b  (sin_idx[SI][lane_lo(J, IW) +: IW]),
            .idx_lo (nx_idx[SI*XW + lane_lo(i, IW) +: IW]),
            .idx_hi (nx_idx[SI*XW + lane_lo(J, IW) +: IW]),
`else
            .idx_a  ('0),
            .idx_b  ('0),
            .idx_lo (idx_unused[SI*XW + lane_lo(i, IW) +: IW]),
            .idx_hi (idx_unused[SI*XW + lane_lo(J, IW) +: IW]),
`endif
            .lo     (nx_d[SI*DW + lane_lo(i, W) +: W]),
            .hi     (nx_d[SI*DW + lane_lo(J, W) +: W])
          );
        end
      end
    end
  end

  // Stage registers: shift together on advance, hold together on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_v    <= '0;
      st_desc <= '0;
      for (int s = 0; s < int'(S); s++) begin
        st_d[s] <= '0;
`ifdef SORT_NET_IDX_EN
        st_idx[s] <= '0;
`endif
      end
    end else if (adv) begin
      st_v[0] <= in_valid;
      for (int s = 1; s < int'(S); s++) begin
        st_v[s] <= st_v[s-1];
      end
      for (int s = 0; s < int'(S); s++) begin
        st_desc[s] <= sin_desc[s];
        st_d[s]    <= nx_d[s*DW +: DW];
`ifdef SORT_NET_IDX_EN
        st_idx[s]  <= nx_idx[s*XW +: XW];
`endif
      end
    end
  end

endmodule

// File: doc/sort_net_pipe.md
SORT_NET_PIPE -- requirements
Module: sort_net_pipe

Interface
REQ-001 SHALL have parameter W, default 8, meaning element width in bits (W >= 1).
REQ-002 SHALL have parameter N, default 4, meaning lane count; legal values 2, 4, 8, 16 only; other values stop elaboration with an error.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  input sample present.
REQ-006 SHALL have port in_ready  output  1  module accepts a sample this cycle.
REQ-007 SHALL have port in_desc  input  1  sort order of the sample: 0 ascending, 1 descending.
REQ-008 SHALL have port x  input  N*W  unsorted lanes; lane i at bits [i*W +: W].
REQ-009 SHALL have port out_valid  output  1  sorted sample present.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the sample.
REQ-011 SHALL have port y  output  N*W  sorted lanes; lane 0 is the minimum (ascending) or the maximum (descending).
REQ-012 SHALL have port y_idx  output  N*log2(N)  original input lane of each y lane; present only with SORT_NET_IDX_EN.

Function
REQ-013 SHALL sort with a bitonic network of S = k(k+1)/2 compare-exchange stages, k = log2(N); S = 3 for N=4, 6 for N=8.
REQ-014 SHALL register the outputs of every stage; latency from accepted input to out_valid SHALL be exactly S cycles with no stalls.
REQ-015 SHALL compare elements unsigned; on equal keys SHALL not swap (without SORT_NET_IDX_EN).
REQ-016 SHALL carry in_desc with its sample through every stage; samples of different order SHALL coexist in the pipeline.
REQ-017 SHALL define advance = !out_valid || out_ready; in_ready SHALL equal advance combinationally.
REQ-018 SHALL shift all stage registers and valid bits by one stage when advance = 1, and hold them all when advance = 0.
REQ-019 SHALL accept a sample only when in_valid && in_ready; otherwise a bubble (valid = 0) enters stage 1.
REQ-020 SHALL keep y and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL sustain one sample per cycle while out_ready = 1.
REQ-022 SHALL not compress bubbles; a stalled pipeline with internal bubbles keeps them.

Reset
REQ-023 SHALL on rst clear all valid bits, all data, desc and idx registers to 0 immediately, regardless of clk.
REQ-024 SHALL drive out_valid = 0, y = 0 (and y_idx = 0) during reset; in_ready = 1 during reset.
REQ-025 SHALL discard all in-flight samples on reset mid-operation; the first output after release comes from a sample accepted after release.

Configuration
REQ-026 SHALL, with macro SORT_NET_IDX_EN defined, tag lane i with index i at input, sort on key {x_i, i} (larger index wins ties as the larger key), and present y_idx.
REQ-027 SHALL, without SORT_NET_IDX_EN, omit y_idx and all index registers; latency and handshake are unchanged.

Structure
REQ-028 SHALL place in shared package sort_pkg: stage-count function for N, the legal-N check, and lane-slice helper constants.
REQ-029 SHALL implement each compare-exchange as sub-module sort_cmp_swap (parameters W, IW; inputs a, b, desc, idx_a, idx_b; outputs lo, hi, idx_lo, idx_hi).

Verification
REQ-030 SHALL cover: N=4, W=8, x = {lane3..0} = {3,9,1,7}, desc=0, out_ready=1 -> after 3 cycles y = {9,7,3,1}, out_valid for 1 cycle.
REQ-031 SHALL cover: same x, desc=1, back-to-back with desc=0 sample -> consecutive outputs {1,3,7,9} then {9,7,3,1}.
REQ-032 SHALL cover: 4 samples streamed, out_ready=0 for 5 cycles after first out_valid -> y held, in_ready=0, no sample lost or duplicated.
REQ-033 SHALL cover: IDX_EN, x = {5,5,5,5}, desc=0 -> y = {5,5,5,5}, y_idx = {3,2,1,0}.
REQ-034 SHALL cover: rst asserted 1 cycle after 2 samples accepted -> out_valid stays 0 until a new sample drains S cycles later.
REQ-035 SHALL cover: N=8, W=16, 1000 random samples, random out_ready -> every y equals reference sort in order, latency 6 when unstalled.
